// File: rtl/bhargava_pkg.sv
// Shared constants and state encoding for the bhargava host session controller.
package bhargava_pkg;

  localparam logic [7:0] CMD_KEY  = 8'hA5;
  localparam logic [7:0] CMD_MODE = 8'h5A;
  localparam logic [7:0] CMD_DATA = 8'h3C;
  localparam logic [7:0] CMD_END  = 8'hC3;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_MODE,
    S_LEN_HI,
    S_LEN_LO,
    S_PAYLOAD
  } state_t;

endpackage

// File: rtl/bhargava_tx_arb.sv
// Shares one uart_tx between ACK/NAK replies and processed core output bytes.
// Replies sit in a 2-deep queue and always win over core bytes.
module bhargava_tx_arb
  import bhargava_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rsp_push,
  input  logic [7:0] rsp_data,
  output logic       rsp_drop,
  input  logic [7:0] mpeg_out,
  input  logic       mpeg_empty,
  output logic       mpeg_rd,
  output logic [7:0] tx_data,
  output logic       tx_en,
  input  logic       tx_busy
);

  logic [7:0] q0;
  logic [7:0] q1;
  logic [1:0] q_cnt;
  logic [7:0] stg;
  logic       stg_vld;
  logic       pend;
  logic       tx_en_q;
  logic       q_pop;
  logic       q_push;

  // Staging may only be refilled when nothing is held and no pop is in flight.
  assign q_pop    = !stg_vld && !pend && (q_cnt != 2'd0);
  assign mpeg_rd  = !rst && !stg_vld && !pend
                  && (q_cnt == 2'd0) && !mpeg_empty;
  assign q_push   = rsp_push && ((q_cnt != 2'd2) || q_pop);
  assign rsp_drop = rsp_push && !q_push;
  assign tx_en    = stg_vld && !tx_busy && !tx_en_q;
  assign tx_data  = stg;

  always_ff @(posedge clk) begin
    if (rst) begin
      q0      <= '0;
      q1      <= '0;
      q_cnt   <= '0;
      stg     <= '0;
      stg_vld <= 1'b0;
      pend    <= 1'b0;
      tx_en_q <= 1'b0;
    end else begin
      tx_en_q <= tx_en;
      pend    <= mpeg_rd;
      if (q_pop) begin
        stg     <= q0;
        stg_vld <= 1'b1;
      end else if (pend) begin
        stg     <= mpeg_out;
        stg_vld <= 1'b1;
      end else if (tx_en) begin
        stg_vld <= 1'b0;
      end
      case ({q_push, q_pop})
        2'b10: begin
          if (q_cnt == 2'd0) q0 <= rsp_data;
          else               q1 <= rsp_data;
          q_cnt <= q_cnt + 2'd1;
        end
        2'b01: begin
          q0    <= q1;
          q_cnt <= q_cnt - 2'd1;
        end
        2'b11: begin
          if (q_cnt == 2'd1) begin
            q0 <= rsp_data;
          end else begin
            q0 <= q1;
            q1 <= rsp_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/bhargava_session_ctrl.sv
// Host command sequencer: parses framed RX commands, loads key/mode,
// meters payload into the core and hands replies to the TX arbiter.
module bhargava_session_ctrl
  import bhargava_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int KEY_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_parity_err,
  output logic                 rx_rd_ready,
  output logic [8*KEY_LEN-1:0] key_out,
  output logic                 mode_out,
  output logic                 key_en,
  output logic [7:0]           mpeg_in,
  output logic                 mpeg_in_en,
  input  logic                 mpeg_full,
  output logic                 stream_end,
  input  logic [7:0]           mpeg_out,
  input  logic                 mpeg_empty,
  output logic                 mpeg_rd,
  output logic [7:0]           tx_data,
  output logic                 tx_en,
  input  logic                 tx_busy,
  output logic                 proto_err
);

  localparam int CNT_W = $clog2(KEY_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_LEN - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_lo_val;
  logic             key_loaded;
  logic             keyen_seen;
  logic             acc;
  logic             rsp_push;
  logic             rsp_nak;
  logic             rsp_drop;
  logic             key_wr;
  logic             key_done;
  logic             mode_wr;
  logic             len_hi;
  logic             len_lo;
  logic             pay_wr;
  logic             end_set;
  logic             perr_abort;

  assign rx_rd_ready = !((state == S_PAYLOAD) && mpeg_full);
  assign acc         = rx_valid && rx_rd_ready;
  assign len_lo_val  = {len[LEN_W-9:0], rx_data};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    rsp_push   = 1'b0;
    rsp_nak    = 1'b0;
    key_wr     = 1'b0;
    key_done   = 1'b0;
    mode_wr    = 1'b0;
    len_hi     = 1'b0;
    len_lo     = 1'b0;
    pay_wr     = 1'b0;
    end_set    = 1'b0;
    perr_abort = 1'b0;
    if (acc && rx_parity_err) begin
      perr_abort = 1'b1;
      rsp_push   = 1'b1;
      rsp_nak    = 1'b1;
      state_n    = S_IDLE;
    end else if (acc) begin
      case (state)
        S_IDLE: begin
          unique case (1'b1)
            rx_data == CMD_KEY:  state_n = S_KEY;
            rx_data == CMD_MODE: state_n = S_MODE;
            rx_data == CMD_DATA: begin
              if (keyen_seen && !stream_end) begin
                state_n = S_LEN_HI;
              end else begin
                rsp_push = 1'b1;
                rsp_nak  = 1'b1;
              end
            end
            rx_data == CMD_END: begin
              end_set  = 1'b1;
              rsp_push = 1'b1;
            end
            default: begin
              rsp_push = 1'b1;
              rsp_nak  = 1'b1;
            end
          endcase
        end
        S_KEY: begin
          key_wr = 1'b1;
          if (cnt == CNT_LAST) begin
            key_done = 1'b1;
            rsp_push = 1'b1;
            state_n  = S_IDLE;
          end
        end
        S_MODE: begin
          mode_wr  = 1'b1;
          rsp_push = 1'b1;
          rsp_nak  = !key_loaded;
          state_n  = S_IDLE;
        end
        S_LEN_HI: begin
          len_hi  = 1'b1;
          state_n = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_lo = 1'b1;
          if (len_lo_val == '0) begin
            rsp_push = 1'b1;
            state_n  = S_IDLE;
          end else begin
            state_n = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          pay_wr = 1'b1;
          if (len == LEN_W'(1)) begin
            rsp_push = 1'b1;
            state_n  = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      len        <= '0;
      key_out    <= '0;
      mode_out   <= 1'b0;
      key_en     <= 1'b0;
      key_loaded <= 1'b0;
      keyen_seen <= 1'b0;
      mpeg_in    <= '0;
      mpeg_in_en <= 1'b0;
      stream_end <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      key_en     <= mode_wr && key_loaded;
      mpeg_in_en <= pay_wr;
      if (pay_wr) mpeg_in <= rx_data;
      if (state != S_KEY) cnt <= '0;
      else if (key_wr)    cnt <= cnt + 1'b1;
      if (key_wr) key_out[8*(KEY_LEN-1-int'(cnt)) +: 8] <= rx_data;
      if (perr_abort)    key_loaded <= 1'b0;
      else if (key_done) key_loaded <= 1'b1;
      if (mode_wr) mode_out <= rx_data[0];
      if (mode_wr && key_loaded) keyen_seen <= 1'b1;
      if (len_hi)      len <= LEN_W'(rx_data);
      else if (len_lo) len <= len_lo_val;
      else if (pay_wr) len <= len - 1'b1;
      if (end_set) stream_end <= 1'b1;
      if ((rsp_push && rsp_nak) || rsp_drop) proto_err <= 1'b1;
    end
  end

  bhargava_tx_arb u_tx_arb (
    .clk        (clk),
    .rst        (rst),
    .rsp_push   (rsp_push),
    .rsp_data   (rsp_nak ? RSP_NAK : RSP_ACK),
    .rsp_drop   (rsp_drop),
    .mpeg_out   (mpeg_out),
    .mpeg_empty (mpeg_empty),
    .mpeg_rd    (mpeg_rd),
    .tx_data    (tx_data),
    .tx_en      (tx_en),
    .tx_busy    (tx_busy)
  );

endmodule

// File: tb/tb_bhargava_session_ctrl.sv
// Bench for bhargava_session_ctrl: directed frames then random traffic
// against a byte-level protocol model.
module tb_bhargava_session_ctrl;
  import bhargava_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_parity_err;
  logic        rx_rd_ready;
  logic [63:0] key_out;
  logic        mode_out;
  logic        key_en;
  logic [7:0]  mpeg_in;
  logic        mpeg_in_en;
  logic        mpeg_full;
  logic        stream_end;
  logic [7:0]  mpeg_out;
  logic        mpeg_empty;
  logic        mpeg_rd;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy;
  logic        proto_err;

  bhargava_session_ctrl dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_parity_err(rx_parity_err), .rx_rd_ready(rx_rd_ready),
    .key_out(key_out), .mode_out(mode_out), .key_en(key_en),
    .mpeg_in(mpeg_in), .mpeg_in_en(mpeg_in_en), .mpeg_full(mpeg_full),
    .stream_end(stream_end), .mpeg_out(mpeg_out),
    .mpeg_empty(mpeg_empty), .mpeg_rd(mpeg_rd),
    .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Protocol model: phase 0 idle,1 key,2 mode,3 len hi,4 len lo,5 payload
  int          m_phase;
  int          m_cnt;
  int          m_len;
  bit          m_key_loaded;
  bit          m_keyen_seen;
  bit          m_ended;
  logic [63:0] m_key;
  bit          m_mode;
  int          m_keyen_cnt;
  logic [7:0]  exp_pay[$];
  logic [7:0]  exp_tx[$];

  task automatic m_reply(input bit nak);
    exp_tx.push_back(nak ? RSP_NAK : RSP_ACK);
  endtask

  task automatic m_reset();
    m_phase = 0; m_cnt = 0; m_len = 0;
    m_key_loaded = 0; m_keyen_seen = 0; m_ended = 0;
    m_key = '0; m_mode = 0; m_keyen_cnt = 0;
    exp_pay.delete(); exp_tx.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit perr);
    if (perr) begin
      m_reply(1); m_key_loaded = 0; m_phase = 0;
      return;
    end
    case (m_phase)
      0: begin
        if (b == 8'hA5) begin m_phase = 1; m_cnt = 0; end
        else if (b == 8'h5A) m_phase = 2;
        else if (b == 8'h3C) begin
          if (m_keyen_seen && !m_ended) m_phase = 3;
          else m_reply(1);
        end
        else if (b == 8'hC3) begin m_ended = 1; m_reply(0); end
        else m_reply(1);
      end
      1: begin
        m_key[63-8*m_cnt -: 8] = b;
        m_cnt++;
        if (m_cnt == 8) begin m_key_loaded = 1; m_reply(0); m_phase = 0; end
      end
      2: begin
        m_mode = b[0];
        if (m_key_loaded) begin
          m_keyen_cnt++; m_keyen_seen = 1; m_reply(0);
        end else m_reply(1);
        m_phase = 0;
      end
      3: begin m_len = int'(b) * 256; m_phase = 4; end
      4: begin
        m_len += int'(b);
        if (m_len == 0) begin m_reply(0); m_phase = 0; end
        else m_phase = 5;
      end
      default: begin
        exp_pay.push_back(b);
        m_len--;
        if (m_len == 0) begin m_reply(0); m_phase = 0; end
      end
    endcase
  endtask

  // UART TX and core output FIFO behaviour
  logic [7:0] core_q[$];
  logic [7:0] core_byte;
  bit         core_pend;
  bit         tx_arm;
  int         tx_left;
  bit         busy_hold;
  bit         tx_en_prev;
  int         ken_seen;
  int         pay_seen;
  bit         stall_en;

  always @(posedge clk) begin
    #1;
    if (tx_arm) begin tx_left = 3; tx_arm = 0; end
    else if (tx_left > 0) tx_left--;
    tx_busy = (tx_left > 0) || busy_hold;
    if (core_pend) begin mpeg_out = core_byte; core_pend = 0; end
    mpeg_empty = (core_q.size() == 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (mpeg_in_en) begin
        pay_seen++;
        if (exp_pay.size() == 0) chk("pay_extra", mpeg_in_en, 0);
        else chk("pay_byte", mpeg_in, exp_pay.pop_front());
      end
      if (tx_en) begin
        chk("tx_b2b", tx_en_prev, 0);
        if (exp_tx.size() == 0) chk("tx_extra", tx_en, 0);
        else chk("tx_byte", tx_data, exp_tx.pop_front());
        tx_arm = 1;
      end
      tx_en_prev = tx_en;
      if (key_en) ken_seen++;
      if (mpeg_rd) begin
        if (core_q.size() == 0) chk("rd_empty", mpeg_rd, 0);
        else begin core_byte = core_q.pop_front(); core_pend = 1; end
      end
    end
  end

  task automatic do_reset();
    rst = 1; rx_valid = 0; rx_parity_err = 0; rx_data = '0;
    mpeg_full = 0; busy_hold = 0; tx_arm = 0; tx_left = 0;
    core_q.delete(); core_pend = 0; tx_en_prev = 0;
    ken_seen = 0; pay_seen = 0;
    m_reset();
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit perr);
    @(negedge clk);
    if (stall_en && $urandom_range(3) == 0) begin
      mpeg_full = 1;
      @(negedge clk);
      chk("rdy_stall", rx_rd_ready, (m_phase == 5) ? 1'b0 : 1'b1);
      mpeg_full = 0;
      @(negedge clk);
    end
    chk("rdy_send", rx_rd_ready, 1);
    rx_data = b; rx_parity_err = perr; rx_valid = 1;
    if (rx_rd_ready) model_byte(b, perr);
    @(negedge clk);
    rx_valid = 0; rx_parity_err = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_tx.size() != 0 || exp_pay.size() != 0) && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk({tag, "_tx_left"}, 64'(exp_tx.size()), 0);
    chk({tag, "_pay_left"}, 64'(exp_pay.size()), 0);
  endtask

  initial begin
    int p0;
    stall_en = 0;
    mpeg_out = '0; mpeg_empty = 1; tx_busy = 0;
    rst = 1; rx_valid = 0; rx_parity_err = 0; rx_data = '0;
    mpeg_full = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", rx_rd_ready, 1);
    chk("rst_outs", {key_out, mode_out, key_en, mpeg_in_en, mpeg_rd,
                     tx_en, stream_end, proto_err}, 0);
    do_reset();

    // DATA before any key, then an unknown byte
    send_byte(8'h3C, 0);
    send_byte(8'h77, 0);
    drain("nak2");
    chk("nak_perr", proto_err, 1);
    chk("nak_nopay", 64'(pay_seen), 0);
    do_reset();
    chk("rst_perr", proto_err, 0);

    // KEY + MODE
    send_byte(8'hA5, 0);
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 0);
    send_byte(8'h5A, 0);
    send_byte(8'h01, 0);
    drain("key");
    chk("key_val", key_out, 64'h0102030405060708);
    chk("mode_val", mode_out, 1);
    chk("key_en_n", 64'(ken_seen), 1);

    // Payload with a mid-frame backpressure stall
    p0 = pay_seen;
    send_byte(8'h3C, 0); send_byte(8'h00, 0); send_byte(8'h03, 0);
    send_byte(8'hAA, 0);
    mpeg_full = 1;
    @(negedge clk);
    chk("rdy_full", rx_rd_ready, 0);
    rx_data = 8'hEE; rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
    repeat (3) @(negedge clk);
    chk("rdy_full2", rx_rd_ready, 0);
    mpeg_full = 0;
    @(negedge clk);
    chk("rdy_rel", rx_rd_ready, 1);
    send_byte(8'hBB, 0); send_byte(8'hCC, 0);
    drain("pay");
    chk("pay_n", 64'(pay_seen - p0), 3);

    // Zero-length DATA frame
    send_byte(8'h3C, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    drain("len0");
    chk("len0_perr", proto_err, 0);

    // Pending ACK must go out before core output bytes
    send_byte(8'h5A, 0);
    @(negedge clk);
    rx_data = 8'h00; rx_valid = 1;
    model_byte(8'h00, 0);
    @(negedge clk);
    rx_valid = 0;
    core_q.push_back(8'hD1); core_q.push_back(8'hD2);
    core_q.push_back(8'hD3);
    exp_tx.push_back(8'hD1); exp_tx.push_back(8'hD2);
    exp_tx.push_back(8'hD3);
    drain("mpeg");
    chk("mode0", mode_out, 0);
    chk("key_en_n2", 64'(ken_seen), 2);

    // Parity error on 2nd payload byte, then END, then DATA refused
    send_byte(8'h3C, 0); send_byte(8'h00, 0); send_byte(8'h04, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 1);
    drain("par");
    chk("par_perr", proto_err, 1);
    send_byte(8'hC3, 0);
    drain("end");
    chk("end_flag", stream_end, 1);
    send_byte(8'h3C, 0);
    drain("post_end");
    chk("end_sticky", stream_end, 1);

    // Reply queue overflow while uart stays busy
    do_reset();
    @(negedge clk);
    busy_hold = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) send_byte(8'h77, 0);
    void'(exp_tx.pop_back());
    busy_hold = 0;
    drain("ovf");
    chk("ovf_perr", proto_err, 1);

    // Random traffic
    do_reset();
    stall_en = 1;
    send_byte(8'hA5, 0);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
    send_byte(8'h5A, 0);
    send_byte(8'($urandom), 0);
    for (int f = 0; f < 60; f++) begin
      int r;
      int ln;
      r = $urandom_range(9);
      if (r <= 1 || r == 9) begin
        send_byte(8'hA5, $urandom_range(24) == 0);
        for (int i = 0; i < 8; i++)
          send_byte(8'($urandom), $urandom_range(24) == 0);
      end else if (r == 2 || (r == 8 && f < 55)) begin
        send_byte(8'h5A, 0);
        send_byte(8'($urandom), $urandom_range(24) == 0);
      end else if (r <= 6) begin
        ln = $urandom_range(4);
        send_byte(8'h3C, 0);
        send_byte(8'h00, 0);
        send_byte(8'(ln), 0);
        for (int i = 0; i < ln; i++)
          send_byte(8'($urandom), $urandom_range(24) == 0);
      end else if (r == 7) begin
        send_byte(8'($urandom), 0);
      end else begin
        send_byte(8'hC3, 0);
      end
    end
    stall_en = 0;
    drain("rand");
    chk("rand_key", key_out, m_key);
    chk("rand_mode", mode_out, m_mode);
    chk("rand_key_en", 64'(ken_seen), 64'(m_keyen_cnt));
    chk("rand_end", stream_end, m_ended);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
